rs_encoder_stream: RTL

Streaming systematic Reed-Solomon encoder over GF(2^8) with field polynomial x^8+x^4+x^3+x^2+1 (0x11D). It is the parametrised successor of the fixed 64-symbol, 4-parity parallel encoder.
- Parity count and maximum message length are parameters.
- Codewords are variable length (shortened codes), delimited by s_last.
- Input and output use valid/ready handshakes with backpressure.
- Sits between the framer and the line interface. Message symbols pass through unchanged, then the parity symbols are appended.

---
 rtl/rs_encoder_stream.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rs_encoder_stream.sv
// Streaming systematic Reed-Solomon encoder over GF(2^8), poly 0x11D.
// Message symbols pass through unchanged; N_PARITY parity symbols follow, highest degree first.
//
//   state    | meaning
//   S_MSG    | accepting message symbols, updating the division LFSR
//   S_PARITY | draining the LFSR remainder as parity symbols
module rs_encoder_stream #(
  parameter int N_PARITY = 4,
  parameter int K_MAX    = 64,
  parameter int FCR      = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  output logic       m_parity,
  input  logic       m_ready,
  output logic       err_len
);

  localparam int MW = $clog2(K_MAX + 1);
  localparam int PW = (N_PARITY > 1) ? $clog2(N_PARITY) : 1;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // Ascending coefficients g[0..N_PARITY-1]; the monic x^N_PARITY term is implicit.
  function automatic logic [N_PARITY*8-1:0] gen_poly();
    logic [7:0]            c [N_PARITY+1];
    logic [7:0]            r;
    logic [N_PARITY*8-1:0] g;
    for (int k = 0; k <= N_PARITY; k++) c[k] = 8'h00;
    c[0] = 8'h01;
    r    = 8'h01;
    for (int k = 0; k < FCR; k++) r = gf_mul(r, 8'h02);
    for (int i = 0; i < N_PARITY; i++) begin
      for (int k = N_PARITY; k >= 1; k--) begin
        if (k <= i + 1) c[k] = c[k-1] ^ gf_mul(c[k], r);
      end
      c[0] = gf_mul(c[0], r);
      r    = gf_mul(r, 8'h02);
    end
    g = '0;
    for (int k = 0; k < N_PARITY; k++) g[k*8 +: 8] = c[k];
    return g;
  endfunction

  localparam logic [N_PARITY*8-1:0] G = gen_poly();

  typedef enum logic {S_MSG, S_PARITY} state_t;

  state_t          state_q, state_d;
  logic [7:0]      lfsr_q [N_PARITY];
  logic [7:0]      lfsr_d [N_PARITY];
  logic [MW-1:0]   msg_cnt_q, msg_cnt_d;
  logic [PW-1:0]   par_cnt_q, par_cnt_d;
  logic [7:0]      m_data_q, m_data_d;
  logic            m_valid_q, m_valid_d;
  logic            m_last_q, m_last_d;
  logic            m_parity_q, m_parity_d;
  logic            err_len_q, err_len_d;
  logic            adv;
  logic            s_ready_c;
  logic [7:0]      fb;

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    msg_cnt_d  = msg_cnt_q;
    par_cnt_d  = par_cnt_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    m_parity_d = m_parity_q;
    err_len_d  = 1'b0;
    adv        = !m_valid_q || m_ready;
    s_ready_c  = !rst && (state_q == S_MSG) && adv;
    fb         = s_data ^ lfsr_q[N_PARITY-1];

    case (state_q)
      S_MSG: begin
        if (s_valid && s_ready_c) begin
          m_data_d   = s_data;
          m_valid_d  = 1'b1;
          m_parity_d = 1'b0;
          m_last_d   = 1'b0;
          lfsr_d[0]  = gf_mul(fb, G[7:0]);
          for (int i = 1; i < N_PARITY; i++) begin
            lfsr_d[i] = lfsr_q[i-1] ^ gf_mul(fb, G[i*8 +: 8]);
          end
          msg_cnt_d = msg_cnt_q + MW'(1);
          if (s_last || (msg_cnt_q == MW'(K_MAX - 1))) begin
            state_d   = S_PARITY;
            par_cnt_d = '0;
            err_len_d = !s_last;
          end
        end else if (adv) begin
          m_valid_d = 1'b0;
        end
      end
      S_PARITY: begin
        if (adv) begin
          m_data_d   = lfsr_q[N_PARITY-1];
          m_parity_d = 1'b1;
          m_valid_d  = 1'b1;
          m_last_d   = (par_cnt_q == PW'(N_PARITY - 1));
          lfsr_d[0]  = 8'h00;
          for (int i = 1; i < N_PARITY; i++) lfsr_d[i] = lfsr_q[i-1];
          par_cnt_d = par_cnt_q + PW'(1);
          if (par_cnt_q == PW'(N_PARITY - 1)) begin
            par_cnt_d = '0;
            msg_cnt_d = '0;
            state_d   = S_MSG;
          end
        end
      end
      default: state_d = S_MSG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_MSG;
      for (int i = 0; i < N_PARITY; i++) lfsr_q[i] <= 8'h00;
      msg_cnt_q  <= '0;
      par_cnt_q  <= '0;
      m_data_q   <= 8'h00;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_parity_q <= 1'b0;
      err_len_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      msg_cnt_q  <= msg_cnt_d;
      par_cnt_q  <= par_cnt_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_parity_q <= m_parity_d;
      err_len_q  <= err_len_d;
    end
  end

  assign s_ready  = s_ready_c;
  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;
  assign m_parity = m_parity_q;
  assign err_len  = err_len_q;

endmodule
